scan_if_arbiter: RTL

Two-requester arbiter and sequencer in front of `mem_reg_mux`. It shares the single scan-side access port (ren/wen/addr/wdata, rdata/ready) between requester 0 (`scan_syn_ctr`) and requester 1 (an on-chip host/BIST master). Round-robin arbitration is applied when both request. The block converts each accepted request into a one-cycle access pulse downstream and returns a one-cycle acknowledge with read data to the granted requester, with an optional timeout on `ready`.

---
 rtl/scan_arb_pkg.sv | 18 +
 rtl/scan_arb_rr2.sv | 22 ++
 rtl/scan_if_arbiter.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/scan_arb_pkg.sv
// scan_arb_pkg: shared types and constants for the scan-port arbiter.
// Holds the sequencer state type, the scan-port widths and the
// all-zero read-data value returned on writes and timeouts.
package scan_arb_pkg;

    localparam int SCAN_ADDR_W = 12;
    localparam int SCAN_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_e;

    localparam logic [SCAN_DATA_W-1:0] rd_zero = '0;

endpackage

// File: rtl/scan_arb_rr2.sv
// scan_arb_rr2: combinational two-way round-robin pick.
// Given the active requester vector and the previous winner, returns a
// one-hot grant. On contention the requester that did not win last time
// is chosen; a lone requester always wins; no request gives no grant.
module scan_arb_rr2 (
    input  logic [1:0] active,
    input  logic       last,
    output logic [1:0] grant
);

    // Pick the winner from the active set, favouring the non-last requester.
    always_comb begin
        grant = 2'b00;
        case (active)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/scan_if_arbiter.sv
// scan_if_arbiter: shares the single scan-side access port between two
// requesters. Each accepted request becomes a one-cycle m_ren/m_wen pulse,
// and completion returns a one-cycle rq_ack (with read data) to the winner.
// All outputs are registered.
// Optional feature: define SCAN_ARB_TIMEOUT_EN to force completion with
// rq_err after TIMEOUT_CYCLES WAIT cycles without m_ready. Without it WAIT
// holds indefinitely and rq_err is tied low.
module scan_if_arbiter
    import scan_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [1:0]                  rq_ren,
    input  logic [1:0]                  rq_wen,
    input  logic [1:0][SCAN_ADDR_W-1:0] rq_addr,
    input  logic [1:0][SCAN_DATA_W-1:0] rq_wdata,
    output logic [SCAN_DATA_W-1:0]      rq_rdata,
    output logic [1:0]                  rq_ack,
    output logic [1:0]                  rq_err,
    output logic                        m_ren,
    output logic                        m_wen,
    output logic [SCAN_ADDR_W-1:0]      m_addr,
    output logic [SCAN_DATA_W-1:0]      m_wdata,
    input  logic [SCAN_DATA_W-1:0]      m_rdata,
    input  logic                        m_ready
);

    if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("scan_if_arbiter: TIMEOUT_CYCLES must be within 1..65535");
    end

    arb_state_e             state, state_n;
    logic                   last, last_n;
    logic                   win, win_n;
    logic                   op_wr, op_wr_n;
    logic [SCAN_ADDR_W-1:0] addr_n;
    logic [SCAN_DATA_W-1:0] wdata_n;
    logic [SCAN_DATA_W-1:0] rdata_n;
    logic                   ren_n, wen_n;
    logic [1:0]             ack_n;
    logic [1:0]             active;
    logic [1:0]             grant;
    logic                   gidx;
    logic [1:0]             win_onehot;

`ifdef SCAN_ARB_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] cnt, cnt_n;
    logic [1:0]  err_n;
`endif

    assign active     = rq_ren | rq_wen;
    assign gidx       = grant[1];
    assign win_onehot = win ? 2'b10 : 2'b01;

    scan_arb_rr2 u_rr2 (
        .active (active),
        .last   (last),
        .grant  (grant)
    );

    // Next-state and next-output decode; outputs are registered below so
    // nothing combinational reaches rq_ack from m_ready.
    always_comb begin
        state_n = state;
        last_n  = last;
        win_n   = win;
        op_wr_n = op_wr;
        addr_n  = m_addr;
        wdata_n = m_wdata;
        ren_n   = 1'b0;
        wen_n   = 1'b0;
        ack_n   = '0;
        rdata_n = rd_zero;
`ifdef SCAN_ARB_TIMEOUT_EN
        err_n   = '0;
        cnt_n   = cnt;
`endif
        case (state)
            IDLE: begin
                if (|active) begin
                    state_n = ISSUE;
                    win_n   = gidx;
                    last_n  = gidx;
                    op_wr_n = rq_wen[gidx];
                    addr_n  = rq_addr[gidx];
                    wdata_n = rq_wdata[gidx];
                    ren_n   = ~rq_wen[gidx];
                    wen_n   = rq_wen[gidx];
`ifdef SCAN_ARB_TIMEOUT_EN
                    cnt_n   = '0;
`endif
                end
            end
            ISSUE, WAIT: begin
                if (m_ready) begin
                    state_n = RESP;
                    ack_n   = win_onehot;
                    rdata_n = op_wr ? rd_zero : m_rdata;
                end
`ifdef SCAN_ARB_TIMEOUT_EN
                else if (state == WAIT && cnt == TO_LAST) begin
                    state_n = RESP;
                    ack_n   = win_onehot;
                    err_n   = win_onehot;
                end else begin
                    state_n = WAIT;
                    if (state == WAIT) begin
                        cnt_n = cnt + 16'd1;
                    end
                end
`else
                else begin
                    state_n = WAIT;
                end
`endif
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, latched transaction and registered outputs; reset aborts any
    // transaction in flight without an acknowledge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            last     <= 1'b1;
            win      <= 1'b0;
            op_wr    <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            m_ren    <= 1'b0;
            m_wen    <= 1'b0;
            rq_ack   <= '0;
            rq_rdata <= '0;
        end else begin
            state    <= state_n;
            last     <= last_n;
            win      <= win_n;
            op_wr    <= op_wr_n;
            m_addr   <= addr_n;
            m_wdata  <= wdata_n;
            m_ren    <= ren_n;
            m_wen    <= wen_n;
            rq_ack   <= ack_n;
            rq_rdata <= rdata_n;
        end
    end

`ifdef SCAN_ARB_TIMEOUT_EN
    // WAIT-cycle counter and registered timeout flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            rq_err <= '0;
        end else begin
            cnt    <= cnt_n;
            rq_err <= err_n;
        end
    end
`else
    assign rq_err = '0;
`endif

endmodule
